modmul_front_1453: RTL

//   Sequential shift-add modular-multiply front end for q = 1453. Takes two residues a, b < 1453,

---
 rtl/gf1453_pkg.sv | 34 +++
 rtl/fold_2p21_1453.sv | 27 ++
 rtl/modmul_front_1453.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/gf1453_pkg.sv
// ---------------------------------------------------------------------------
// gf1453_pkg
//   Shared constants and types for arithmetic modulo q = 1453.
//   Used by the shift-add multiply front end and by the 2^21 fold block.
//
//   Q      : modulus
//   OPW    : operand width, ceil(log2(Q))
//   OUTW   : width of the folded product handed to the Barrett reducer
//   PRODW  : width of the raw product accumulator (2*OPW)
//   FOLD   : 2^21 mod Q, the weight of product bit 21 after folding
//   ITERS  : number of shift-add iterations (one per multiplier bit)
// ---------------------------------------------------------------------------
package gf1453_pkg;

    localparam int Q     = 1453;
    localparam int OPW   = 11;
    localparam int OUTW  = 21;
    localparam int PRODW = 22;

    localparam logic [OUTW-1:0] FOLD  = 21'd473;
    localparam logic [3:0]      ITERS = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // True when an operand is a proper residue, i.e. strictly below Q.
    function automatic logic in_range(input logic [OPW-1:0] v);
        return (v < OPW'(Q));
    endfunction

endpackage

// File: rtl/fold_2p21_1453.sv
// ---------------------------------------------------------------------------
// fold_2p21_1453
//   Combinational 22-bit -> 21-bit fold that keeps the value congruent
//   modulo 1453. Bit 21 (weight 2^21) is replaced by 2^21 mod 1453 = 473.
//   For any product of two residues below 1453 the result stays below 2^21,
//   so the 21-bit sum cannot wrap.
//
//   Ports
//     prod   in   22  raw product
//     folded out  21  congruent folded value
// ---------------------------------------------------------------------------
module fold_2p21_1453
    import gf1453_pkg::*;
(
    input  logic [PRODW-1:0] prod,
    output logic [OUTW-1:0]  folded
);

    logic [OUTW-1:0] low_part;

    assign low_part = prod[OUTW-1:0];

    // Only the single overflow bit needs folding; the add is safe for
    // in-range products (worst case 1452^2 folds to 11625).
    assign folded = prod[PRODW-1] ? (low_part + FOLD) : low_part;

endmodule

// File: rtl/modmul_front_1453.sv
// ---------------------------------------------------------------------------
// modmul_front_1453
//   Sequential shift-add modular-multiply front end for q = 1453.
//   Accepts a pair of residues, builds a*b over 11 shift-add iterations and
//   folds the 22-bit product into a 21-bit value congruent to a*b mod 1453,
//   ready for the downstream combinational Barrett reducer.
//   One product in flight; valid/ready handshakes on both sides.
//
//   Timing: operands accepted at edge T, iterations at edges T+1..T+11,
//   folded result registered at edge T+12 (out_valid high from T+12),
//   held until the output handshake, which returns the block to IDLE.
//
//   Ports
//     clk        in   1   clock, rising edge
//     rst        in   1   asynchronous reset, active-high
//     in_valid   in   1   operand pair valid
//     in_ready   out  1   high only while IDLE
//     in_a       in   11  multiplicand
//     in_b       in   11  multiplier, consumed LSB first
//     out_valid  out  1   out_data valid (DONE state)
//     out_ready  in   1   downstream accepts out_data
//     out_data   out  21  folded product
//     out_err    out  1   operand out of range (only with the macro below)
//
//   Build option
//     MODMUL_RANGE_CHECK_EN : flags in_a >= Q or in_b >= Q at accept; the
//     flagged operation completes with normal timing, out_data = 0 and
//     out_err = 1. Without the macro the out_err port does not exist.
// ---------------------------------------------------------------------------
module modmul_front_1453
    import gf1453_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  in_a,
    input  logic [OPW-1:0]  in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OUTW-1:0] out_data
`ifdef MODMUL_RANGE_CHECK_EN
    ,
    output logic            out_err
`endif
);

    state_t            state;
    state_t            state_next;

    logic [PRODW-1:0]  acc;
    logic [PRODW-1:0]  a_sh;
    logic [OPW-1:0]    b_sh;
    logic [3:0]        cnt;
    logic [OUTW-1:0]   folded;
    logic              last_iter;

`ifdef MODMUL_RANGE_CHECK_EN
    logic              range_err;
`endif

    // The iteration counter reaching ITERS marks the finalize cycle that
    // follows the eleventh shift-add step; no early exit on b_sh == 0.
    assign last_iter = (cnt == ITERS);

    fold_2p21_1453 u_fold (
        .prod   (acc),
        .folded (folded)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; both handshake outputs are pure
    // decodes of the state so they are glitch-free relative to the datapath.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Shift-add datapath and output register. Operands are loaded on the
    // accept edge, one multiplier bit is consumed per BUSY edge, and the
    // folded product is captured on the finalize edge. out_data is only
    // written there, so it holds its value through DONE and afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            cnt      <= '0;
            out_data <= '0;
`ifdef MODMUL_RANGE_CHECK_EN
            range_err <= 1'b0;
            out_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh <= {{(PRODW-OPW){1'b0}}, in_a};
                        b_sh <= in_b;
                        acc  <= '0;
                        cnt  <= '0;
`ifdef MODMUL_RANGE_CHECK_EN
                        range_err <= !(in_range(in_a) && in_range(in_b));
`endif
                    end
                end
                BUSY: begin
                    if (!last_iter) begin
                        if (b_sh[0]) begin
                            acc <= acc + a_sh;
                        end
                        a_sh <= a_sh << 1;
                        b_sh <= b_sh >> 1;
                        cnt  <= cnt + 4'd1;
                    end else begin
`ifdef MODMUL_RANGE_CHECK_EN
                        out_data <= range_err ? '0 : folded;
                        out_err  <= range_err;
`else
                        out_data <= folded;
`endif
                    end
                end
                DONE: begin
`ifdef MODMUL_RANGE_CHECK_EN
                    if (out_ready) begin
                        out_err <= 1'b0;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule
